// File: rtl/usb3_vend_req_ctl.sv
// EP0 vendor-request controller: decodes register ops into a bank of 16-bit
// control registers and passes all other requests through a valid/ready FIFO.
module usb3_vend_req_ctl #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    local_clk,
  input  logic                    reset_n,
  input  logic                    vend_req_act,
  input  logic [7:0]              vend_req_request,
  input  logic [15:0]             vend_req_val,
  input  logic [15:0]             vend_req_index,
  output logic [16*NUM_REGS-1:0]  reg_out,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_request,
  output logic [15:0]             cmd_val,
  output logic [15:0]             cmd_index,
  output logic                    cmd_overflow,
  output logic [15:0]             req_count
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {StIdle, StDecode, StExec} state_e;
  typedef enum logic [2:0] {OpWrite, OpSet, OpClr, OpClrStatus, OpPush} op_e;

  state_e             r_state, w_state_nxt;
  op_e                r_op, w_op_nxt;
  logic               r_act_d;
  logic [7:0]         r_req;
  logic [15:0]        r_val;
  logic [15:0]        r_idx;
  logic [15:0]        r_regs [NUM_REGS];
  logic [7:0]         r_fifo_req [FIFO_DEPTH];
  logic [15:0]        r_fifo_val [FIFO_DEPTH];
  logic [15:0]        r_fifo_idx [FIFO_DEPTH];
  logic [PtrW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]    r_fifo_cnt, w_fifo_cnt_nxt;
  logic               r_overflow;
  logic [15:0]        r_req_count;

  logic               w_detect, w_exec, w_push, w_pop, w_full, w_push_ok, w_drop;
  logic [RegIdxW-1:0] w_reg_sel;

  assign w_detect  = vend_req_act & ~r_act_d & (r_state == StIdle);
  assign w_exec    = (r_state == StExec);
  assign w_push    = w_exec & (r_op == OpPush);
  assign w_pop     = cmd_valid & cmd_ready;
  assign w_full    = (r_fifo_cnt == CntW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_reg_sel = r_idx[RegIdxW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_detect) w_state_nxt = StDecode;
      StDecode: w_state_nxt = StExec;
      StExec:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_op_nxt = OpPush;
    case (r_req)
      8'h01:   w_op_nxt = OpWrite;
      8'h02:   w_op_nxt = OpSet;
      8'h03:   w_op_nxt = OpClr;
      8'h04:   w_op_nxt = OpClrStatus;
      default: w_op_nxt = OpPush;
    endcase
  end

  always_comb begin
    w_fifo_cnt_nxt = r_fifo_cnt;
    if (w_push_ok && !w_pop) begin
      w_fifo_cnt_nxt = r_fifo_cnt + CntW'(1);
    end else if (!w_push_ok && w_pop) begin
      w_fifo_cnt_nxt = r_fifo_cnt - CntW'(1);
    end
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_act_d <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_act_d <= vend_req_act;
    end
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req <= '0;
      r_val <= '0;
      r_idx <= '0;
      r_op  <= OpPush;
    end else begin
      if (w_detect) begin
        r_req <= vend_req_request;
        r_val <= vend_req_val;
        r_idx <= vend_req_index;
      end
      if (r_state == StDecode) begin
        r_op <= w_op_nxt;
      end
    end
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_overflow  <= 1'b0;
      r_req_count <= '0;
    end else if (w_exec) begin
      r_req_count <= r_req_count + 16'd1;
      case (r_op)
        OpWrite:     r_regs[w_reg_sel] <= r_val;
        OpSet:       r_regs[w_reg_sel] <= r_regs[w_reg_sel] | r_val;
        OpClr:       r_regs[w_reg_sel] <= r_regs[w_reg_sel] & ~r_val;
        OpClrStatus: r_overflow <= 1'b0;
        default:     if (w_drop) r_overflow <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_fifo_req[k] <= '0;
        r_fifo_val[k] <= '0;
        r_fifo_idx[k] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo_req[r_wr_ptr] <= r_req;
        r_fifo_val[r_wr_ptr] <= r_val;
        r_fifo_idx[r_wr_ptr] <= r_idx;
        r_wr_ptr <= (r_wr_ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      end
      r_fifo_cnt <= w_fifo_cnt_nxt;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) reg_out[16*k +: 16] = r_regs[k];
  end

  assign cmd_valid    = (r_fifo_cnt != '0);
  assign cmd_request  = r_fifo_req[r_rd_ptr];
  assign cmd_val      = r_fifo_val[r_rd_ptr];
  assign cmd_index    = r_fifo_idx[r_rd_ptr];
  assign cmd_overflow = r_overflow;
  assign req_count    = r_req_count;

endmodule

// File: tb/tb_usb3_vend_req_ctl.sv
// Directed bench for usb3_vend_req_ctl: register ops, FIFO fill/overflow/drain,
// full-with-pop, reset mid-operation, and counter wrap with CLR_STATUS.
module tb_usb3_vend_req_ctl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         act = 1'b0;
  logic [7:0]   req = '0;
  logic [15:0]  val = '0;
  logic [15:0]  idx = '0;
  logic [127:0] reg_out;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [7:0]   cmd_request;
  logic [15:0]  cmd_val;
  logic [15:0]  cmd_index;
  logic         cmd_overflow;
  logic [15:0]  req_count;

  int errors = 0;
  int checks = 0;

  usb3_vend_req_ctl #(.NUM_REGS(8), .FIFO_DEPTH(4)) dut (
    .local_clk        (clk),
    .reset_n          (rst_n),
    .vend_req_act     (act),
    .vend_req_request (req),
    .vend_req_val     (val),
    .vend_req_index   (idx),
    .reg_out          (reg_out),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_request      (cmd_request),
    .cmd_val          (cmd_val),
    .cmd_index        (cmd_index),
    .cmd_overflow     (cmd_overflow),
    .req_count        (req_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    act = 1'b0;
    cmd_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle strobe; returns at the negedge after the EXEC edge.
  task automatic do_req(input logic [7:0] rq, input logic [15:0] ix, input logic [15:0] vl);
    @(negedge clk);
    act = 1'b1; req = rq; idx = ix; val = vl;
    @(negedge clk);
    act = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    cmd_ready = 1'b0;
    do_req(8'h01, 16'h0000, 16'hFFFF);
    do_req(8'h77, 16'h0001, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (reg_out !== '0) begin
      errors++; $display("FAIL reset_reg_out: got %h expected 0", reg_out);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid);
    end
    checks++;
    if (cmd_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", cmd_overflow);
    end
    checks++;
    if (req_count !== 16'h0000) begin
      errors++; $display("FAIL reset_req_count: got %h expected 0000", req_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reg_write();
    logic [127:0] exp;
    apply_reset();
    exp = '0;
    exp[47:32] = 16'hBEEF;
    @(negedge clk);
    act = 1'b1; req = 8'h01; idx = 16'h0002; val = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (reg_out[47:32] !== 16'h0000) begin
      errors++; $display("FAIL write_early: got %h expected 0000", reg_out[47:32]);
    end
    @(negedge clk);
    checks++;
    if (reg_out[47:32] !== 16'hBEEF) begin
      errors++; $display("FAIL write_latency: got %h expected beef", reg_out[47:32]);
    end
    @(negedge clk);
    act = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (reg_out !== exp) begin
      errors++; $display("FAIL write_reg_out: got %h expected %h", reg_out, exp);
    end
    checks++;
    if (req_count !== 16'd1) begin
      errors++; $display("FAIL write_req_count: got %0d expected 1", req_count);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL write_no_push: got %b expected 0", cmd_valid);
    end
  endtask

  task automatic test_set_clr();
    logic [127:0] exp;
    apply_reset();
    exp = '0;
    exp[95:80] = 16'h0FC0;
    do_req(8'h01, 16'h0005, 16'h00F0);
    do_req(8'h02, 16'h000D, 16'h0F00);
    checks++;
    if (reg_out[95:80] !== 16'h0FF0) begin
      errors++; $display("FAIL set_bits: got %h expected 0ff0", reg_out[95:80]);
    end
    do_req(8'h03, 16'h0005, 16'h0030);
    checks++;
    if (reg_out !== exp) begin
      errors++; $display("FAIL clr_bits: got %h expected %h", reg_out, exp);
    end
    checks++;
    if (req_count !== 16'd3) begin
      errors++; $display("FAIL set_clr_count: got %0d expected 3", req_count);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] rq;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      rq = 8'h40 + 8'(i);
      do_req(rq, {8'h00, rq}, {rq, 8'h00});
    end
    checks++;
    if (cmd_valid !== 1'b1 || cmd_request !== 8'h40) begin
      errors++; $display("FAIL fifo_head: got v=%b req=%h expected v=1 req=40", cmd_valid, cmd_request);
    end
    checks++;
    if (cmd_val !== 16'h4000 || cmd_index !== 16'h0040) begin
      errors++; $display("FAIL fifo_head_fields: got val=%h idx=%h expected 4000/0040", cmd_val, cmd_index);
    end
    checks++;
    if (cmd_overflow !== 1'b1) begin
      errors++; $display("FAIL fifo_overflow: got %b expected 1", cmd_overflow);
    end
    checks++;
    if (req_count !== 16'd5) begin
      errors++; $display("FAIL fifo_req_count: got %0d expected 5", req_count);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rq = 8'h40 + 8'(i);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_request !== rq) begin
        errors++; $display("FAIL fifo_pop_%0d: got v=%b req=%h expected v=1 req=%h", i, cmd_valid, cmd_request, rq);
      end
      @(negedge clk);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL fifo_empty: got %b expected 0", cmd_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_overflow !== 1'b1) begin
      errors++; $display("FAIL ready_when_empty: got v=%b ovf=%b expected v=0 ovf=1", cmd_valid, cmd_overflow);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_seq [4];
    apply_reset();
    for (int i = 0; i < 4; i++) do_req(8'h40 + 8'(i), 16'h0000, 16'h0000);
    @(negedge clk);
    act = 1'b1; req = 8'h50; idx = 16'h0000; val = 16'h0000;
    @(negedge clk);
    act = 1'b0;
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_overflow !== 1'b0) begin
      errors++; $display("FAIL full_pop_overflow: got %b expected 0", cmd_overflow);
    end
    checks++;
    if (cmd_request !== 8'h41) begin
      errors++; $display("FAIL full_pop_head: got %h expected 41", cmd_request);
    end
    exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43; exp_seq[3] = 8'h50;
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_request !== exp_seq[i]) begin
        errors++; $display("FAIL full_pop_drain_%0d: got v=%b req=%h expected v=1 req=%h", i, cmd_valid, cmd_request, exp_seq[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_empty: got %b expected 0", cmd_valid);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    @(negedge clk);
    act = 1'b1; req = 8'h01; idx = 16'h0000; val = 16'h1234;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (reg_out !== '0 || req_count !== 16'h0000) begin
      errors++; $display("FAIL midop_async: got reg=%h cnt=%h expected 0/0", reg_out, req_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (reg_out !== '0 || req_count !== 16'h0000) begin
      errors++; $display("FAIL midop_held_act: got reg=%h cnt=%h expected 0/0", reg_out, req_count);
    end
    act = 1'b0;
    @(negedge clk);
    act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (reg_out[15:0] !== 16'h1234 || req_count !== 16'd1) begin
      errors++; $display("FAIL midop_retrigger: got reg0=%h cnt=%h expected 1234/0001", reg_out[15:0], req_count);
    end
  endtask

  task automatic test_wrap_clr_status();
    apply_reset();
    for (int i = 0; i < 5; i++) do_req(8'h60 + 8'(i), 16'h0000, 16'h0000);
    // Stand-in for 65534 earlier requests.
    @(negedge clk);
    force dut.r_req_count = 16'hFFFE;
    #1 release dut.r_req_count;
    do_req(8'h65, 16'h0000, 16'h0000);
    checks++;
    if (req_count !== 16'hFFFF || cmd_overflow !== 1'b1) begin
      errors++; $display("FAIL wrap_pre: got cnt=%h ovf=%b expected ffff/1", req_count, cmd_overflow);
    end
    do_req(8'h04, 16'h0000, 16'h0000);
    checks++;
    if (req_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_count: got %h expected 0000", req_count);
    end
    checks++;
    if (cmd_overflow !== 1'b0) begin
      errors++; $display("FAIL clr_status: got %b expected 0", cmd_overflow);
    end
    checks++;
    if (cmd_valid !== 1'b1 || cmd_request !== 8'h60) begin
      errors++; $display("FAIL clr_status_fifo: got v=%b req=%h expected v=1 req=60", cmd_valid, cmd_request);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_reg_write();
    test_set_clr();
    test_fifo_overflow();
    test_full_pop();
    test_reset_mid_op();
    test_wrap_clr_status();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
